uart_tx_fifo_cfg: RTL and testbench
===================================

Name: uart_tx_fifo_cfg

Overview:
Parametrised next-generation UART transmitter with an internal baud divider, a transmit FIFO and runtime frame configuration. Supported frames: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
- Producers push bytes through a valid/ready handshake.
- The block serialises queued bytes back-to-back, LSB first, onto the tx line.
- Sits between the system bus/controller logic and the board UART pin, replacing the fixed 8N1 transmitter.

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate; DIV = CLOCK_FREQ / BAUD_RATE (integer division, truncating); DIV >= 2 required, elaboration error otherwise.
FIFO_DEPTH, 16, transmit FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous reset, active-low.
in_data  input  8  byte to transmit; only bits [N-1:0] are sent, where N is the data-bit count.
in_valid  input  1  producer has a byte.
in_ready  output  1  FIFO can accept; equals !full.
cfg_data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits.
cfg_parity  input  2  00=none, 01=even, 10=odd, 11=none.
cfg_stop2  input  1  0=one stop bit, 1=two stop bits.
tx  output  1  serial line, idle high.
tx_busy  output  1  high while a frame is on the line.
frame_done  output  1  one-cycle pulse at the end of each frame.
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at a clock edge), effective next edge:
  - tx=1, tx_busy=0, frame_done=0.
  - fifo_level=0, in_ready=1.
  - FSM returns to IDLE and the baud counter is cleared.
  - Reset mid-frame aborts the frame; tx is high after that edge and queued bytes are discarded.
- FIFO:
  - Write on in_valid & in_ready.
  - in_ready is derived from registered occupancy, so no write is accepted while full, even in a cycle where a pop occurs.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No bypass: a byte always passes through FIFO storage.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, tx_busy=0. When FIFO is non-empty, pop the head entry and latch the byte plus cfg_data_bits, cfg_parity and cfg_stop2; clear the baud counter; go to START.
  - Config changes during a frame have no effect until the next pop.
  - START: tx=0 for DIV cycles, then DATA with bit index 0.
  - DATA: tx=data[idx] for DIV cycles per bit, LSB first. After bit N-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx = XOR of the N sent bits for even parity, or its inverse for odd, for DIV cycles.
  - STOP: tx=1 for DIV cycles per stop bit (1 or 2).
- End of last stop bit:
  - frame_done pulses for one cycle, on the final cycle of the stop bit.
  - If the FIFO is non-empty, pop and go directly to START, so the next start bit begins on the following cycle with zero idle gap. Otherwise go to IDLE.
- Baud counter counts 0..DIV-1 and advances state at DIV-1. Every bit is exactly DIV clocks.
- Frame length = DIV × (1 + N + P + S) clocks, where P is 0 or 1 and S is 1 or 2.
- tx_busy is high in START, DATA, PARITY and STOP; low only in IDLE. It stays high continuously across back-to-back frames.
- Latency: handshake accepted at edge E with the FIFO empty and the FSM idle:
  - fifo_level=1 after E.
  - Pop at E+1, fifo_level=0.
  - tx=0 and tx_busy=1 after E+2.
- tx is a registered output, glitch-free.

Test Plan:
- Use CLOCK_FREQ=800, BAUD_RATE=100 (DIV=8), FIFO_DEPTH=4 throughout.
- 8N1, push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 clocks. tx_busy high 80 clocks. frame_done one pulse. tx low exactly 2 edges after the handshake edge.
- 7E1, push 0x53 -> data 1,1,0,0,1,0,1, parity 0 (even), stop 1; 80 clocks. Same byte with cfg_parity=10 -> parity bit 1.
- 5N2, push 0xFF -> data 1,1,1,1,1 then stop 1,1; 64 clocks. Bits 7:5 are not sent.
- FIFO behaviour:
  - Push 6 bytes without pause -> 4 entries fill, frame 1 pops, in_ready low whenever fifo_level=4.
  - All 6 bytes are sent in order, back-to-back with no idle cycle.
  - tx_busy stays high continuously.
  - Exactly 6 frame_done pulses.
- Reset and mid-frame config:
  - Assert rst_n=0 during the DATA bit 3 of 0x3C with 2 bytes queued -> next edge tx=1, tx_busy=0, fifo_level=0, in_ready=1, no further frames.
  - Change cfg_data_bits mid-frame -> the current frame keeps its latched format.

Source files
------------

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a transmit FIFO, internal baud divider and per-frame format (5-8 data bits, parity, 1/2 stop).
// Latency: push to start bit on tx is 2 edges when idle; back-to-back frames are sent without an idle gap.
module uart_tx_fifo_cfg #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo_cfg: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
        $error("uart_tx_fifo_cfg: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic            stop_idx;
    logic [7:0]      data_q;
    logic [1:0]      bits_q;
    logic [1:0]      par_q;
    logic            stop2_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level;
    logic            push, pop, empty;
    logic            bit_end, last_data, par_en, frame_end;
    logic [2:0]      nb_m1;
    logic [7:0]      mask;
    logic            par_bit;
    logic            tx_d, busy_d, done_d;

    assign in_ready   = (level != (AW+1)'(FIFO_DEPTH));
    assign fifo_level = level;
    assign empty      = (level == '0);
    assign push       = in_valid && in_ready;

    assign bit_end    = (cnt == CW'(DIV - 1));
    assign nb_m1      = 3'd4 + {1'b0, bits_q};
    assign last_data  = (idx == nb_m1);
    assign par_en     = (par_q == 2'b01) || (par_q == 2'b10);
    assign frame_end  = (state == S_STOP) && bit_end && (stop_idx == stop2_q);
    assign mask       = 8'hFF >> (2'd3 - bits_q);
    // Even parity bit is the XOR of the sent bits; odd is its inverse.
    assign par_bit    = (^(data_q & mask)) ^ (par_q == 2'b10);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            data_q   <= '0;
            bits_q   <= '0;
            par_q    <= '0;
            stop2_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx         <= tx_d;
            tx_busy    <= busy_d;
            frame_done <= done_d;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (pop) begin
                // Format is captured per frame so later config writes only affect the next byte.
                data_q   <= mem[rd_ptr];
                bits_q   <= cfg_data_bits;
                par_q    <= cfg_parity;
                stop2_q  <= cfg_stop2;
                cnt      <= '0;
                idx      <= '0;
                stop_idx <= 1'b0;
            end else if (state != S_IDLE) begin
                cnt <= bit_end ? '0 : cnt + CW'(1);
                if (bit_end && state == S_DATA) begin
                    idx <= idx + 3'd1;
                end
                if (bit_end && state == S_STOP) begin
                    stop_idx <= stop_idx + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && last_data) state_nxt = par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (frame_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state != S_IDLE);
        done_d = frame_end;
        case (state)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[idx];
            S_PARITY: tx_d = par_bit;
            default:  tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: table-driven frames, FIFO/reset/config corner sequences, random traffic vs a line-level model.
module tb_uart_tx_fifo_cfg;
    localparam int DIV   = 8;
    localparam int DEPTH = 4;
    localparam int NE    = 16384;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] cfg_data_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       tx;
    logic       tx_busy;
    logic       frame_done;
    logic [2:0] fifo_level;

    uart_tx_fifo_cfg #(.CLOCK_FREQ(800), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Expected line waveform indexed by edge number; a frame popped at edge P drives tx after edges P+1..P+L.
    bit exp_tx [NE];
    bit exp_busy [NE];
    bit exp_done [NE];
    bit log_tx [NE];
    bit log_busy [NE];
    bit log_done [NE];
    logic [7:0] mq [$];
    int e, line_end, n_acc;
    int total, bad;

    typedef struct {
        logic [7:0]  dat;
        logic [1:0]  bits;
        logic [1:0]  par;
        logic        stop2;
        int          nbits;
        logic [11:0] pat;
        int          len;
    } vec_t;
    vec_t vt [7];

    task automatic chk(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", nm, e, act, expv);
        end
    endtask

    task automatic model_reset(int r);
        mq.delete();
        for (int k = r; k < NE; k++) begin
            exp_tx[k] = 1'b1;
            exp_busy[k] = 1'b0;
            exp_done[k] = 1'b0;
        end
        line_end = r;
    endtask

    task automatic schedule(int p, logic [7:0] d, logic [1:0] b, logic [1:0] par, logic s2);
        int n, ones, len;
        bit seq [$];
        n = int'(b) + 5;
        ones = 0;
        seq.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            seq.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 2'b01) seq.push_back(ones % 2 == 1);
        else if (par == 2'b10) seq.push_back(ones % 2 == 0);
        seq.push_back(1'b1);
        if (s2) seq.push_back(1'b1);
        len = seq.size() * DIV;
        for (int k = 0; k < len; k++) begin
            if (p + 1 + k < NE) begin
                exp_tx[p + 1 + k] = seq[k / DIV];
                exp_busy[p + 1 + k] = 1'b1;
            end
        end
        if (p + len < NE) exp_done[p + len] = 1'b1;
        line_end = p + len;
    endtask

    // One clock: model the edge from the inputs currently driven, then compare all outputs at the negedge.
    task automatic cycle();
        logic acc;
        acc = in_valid && (mq.size() < DEPTH);
        @(posedge clk);
        e = e + 1;
        if (!rst_n) begin
            model_reset(e);
        end else begin
            if (mq.size() > 0 && e >= line_end) begin
                schedule(e, mq.pop_front(), cfg_data_bits, cfg_parity, cfg_stop2);
            end
            if (acc) begin
                mq.push_back(in_data);
                n_acc++;
            end
        end
        @(negedge clk);
        log_tx[e] = tx;
        log_busy[e] = tx_busy;
        log_done[e] = frame_done;
        chk("tx", int'(tx), int'(exp_tx[e]));
        chk("tx_busy", int'(tx_busy), int'(exp_busy[e]));
        chk("frame_done", int'(frame_done), int'(exp_done[e]));
        chk("fifo_level", int'(fifo_level), mq.size());
        chk("in_ready", int'(in_ready), (mq.size() < DEPTH) ? 1 : 0);
    endtask

    function automatic int count_busy(int a, int b);
        int c = 0;
        for (int k = a; k <= b; k++) c += int'(log_busy[k]);
        return c;
    endfunction

    function automatic int count_done(int a, int b);
        int c = 0;
        for (int k = a; k <= b; k++) c += int'(log_done[k]);
        return c;
    endfunction

    task automatic set_cfg(logic [1:0] b, logic [1:0] p, logic s);
        cfg_data_bits = b;
        cfg_parity = p;
        cfg_stop2 = s;
    endtask

    task automatic push_one(logic [7:0] d, output int hs);
        in_data = d;
        in_valid = 1'b1;
        cycle();
        hs = e;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(vec_t v);
        int hs;
        logic [11:0] got;
        set_cfg(v.bits, v.par, v.stop2);
        push_one(v.dat, hs);
        repeat (v.len + 8) cycle();
        chk("lat_idle", int'(log_tx[hs + 1]), 1);
        chk("lat_start", int'(log_tx[hs + 2]), 0);
        got = '0;
        for (int i = 0; i < v.nbits; i++) got[i] = log_tx[hs + 2 + DIV * i + DIV / 2];
        chk("pattern", int'(got), int'(v.pat));
        chk("busy_len", count_busy(hs, e), v.len);
        chk("done_cnt", count_done(hs, e), 1);
    endtask

    initial begin
        int hs, hs0, acc_cnt, guard, full_rdy, max_lvl, prev;
        logic [7:0] fb [6];
        logic [11:0] got;
        total = 0; bad = 0; e = 0; n_acc = 0;
        model_reset(0);

        vt[0] = '{8'hA5, 2'b11, 2'b00, 1'b0, 10, 12'h34A, 80};
        vt[1] = '{8'h53, 2'b10, 2'b01, 1'b0, 10, 12'h2A6, 80};
        vt[2] = '{8'h53, 2'b10, 2'b10, 1'b0, 10, 12'h3A6, 80};
        vt[3] = '{8'hFF, 2'b00, 2'b00, 1'b1, 8,  12'h0FE, 64};
        vt[4] = '{8'h2D, 2'b01, 2'b01, 1'b1, 10, 12'h35A, 80};
        vt[5] = '{8'h00, 2'b11, 2'b11, 1'b0, 10, 12'h200, 80};
        vt[6] = '{8'h01, 2'b11, 2'b10, 1'b1, 12, 12'hC02, 96};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        set_cfg(2'b11, 2'b00, 1'b0);
        repeat (3) cycle();
        chk("rst_tx", int'(tx), 1);
        chk("rst_level", int'(fifo_level), 0);
        rst_n = 1'b1;
        repeat (2) cycle();

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Six bytes pushed without pause into a 4-deep FIFO.
        set_cfg(2'b11, 2'b00, 1'b0);
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        acc_cnt = 0; guard = 0; full_rdy = 0; max_lvl = 0; hs0 = e + 1;
        while (acc_cnt < 6 && guard < 400) begin
            in_data = fb[acc_cnt];
            in_valid = 1'b1;
            prev = n_acc;
            cycle();
            if (n_acc > prev) acc_cnt++;
            if (fifo_level == 3'd4 && in_ready) full_rdy++;
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            guard++;
        end
        in_valid = 1'b0;
        chk("fifo_accept", acc_cnt, 6);
        repeat (6 * 80 + 20) cycle();
        chk("full_rdy", full_rdy, 0);
        chk("max_level", max_lvl, 4);
        chk("b2b_busy", count_busy(hs0 + 2, hs0 + 2 + 479), 480);
        chk("b2b_end", int'(log_busy[hs0 + 2 + 480]), 0);
        chk("b2b_done", count_done(hs0, e), 6);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        push_one(8'h3C, hs);
        in_data = 8'h77; in_valid = 1'b1; cycle();
        in_data = 8'h88; cycle();
        in_valid = 1'b0;
        while (e < hs + 2 + DIV * 4 + 2) cycle();
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_tx", int'(tx), 1);
        chk("mid_rst_busy", int'(tx_busy), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_rdy", int'(in_ready), 1);
        rst_n = 1'b1;
        hs0 = e + 1;
        repeat (200) cycle();
        chk("post_rst_done", count_done(hs0, e), 0);
        chk("post_rst_busy", count_busy(hs0, e), 0);

        // Config change mid-frame keeps the latched 8N1 format.
        set_cfg(2'b11, 2'b00, 1'b0);
        push_one(8'hC3, hs);
        repeat (20) cycle();
        set_cfg(2'b00, 2'b01, 1'b1);
        repeat (70) cycle();
        got = '0;
        for (int i = 0; i < 10; i++) got[i] = log_tx[hs + 2 + DIV * i + DIV / 2];
        chk("cfg_pattern", int'(got), 12'h386);
        chk("cfg_busy_len", count_busy(hs, e), 80);
        chk("cfg_done", count_done(hs, e), 1);

        // Random traffic with occasional format changes at arbitrary times.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom % 3 == 0);
            in_data = 8'($urandom);
            if ($urandom % 40 == 0) set_cfg(2'($urandom), 2'($urandom), 1'($urandom));
            cycle();
        end
        in_valid = 1'b0;
        guard = 0;
        while ((mq.size() > 0 || e < line_end + 2) && guard < 1200) begin
            cycle();
            guard++;
        end
        chk("drain", (mq.size() == 0 && e >= line_end + 2) ? 1 : 0, 1);
        chk("final_busy", int'(tx_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
